// File: rtl/inst_mem_sync.sv
// Synchronous-read instruction memory for the fetch stage: valid/ready fetch
// requests, a stallable one-cycle response register and a run-time load port.
module inst_mem_sync #(
    parameter int                ADDR_W   = 10,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       pc_in,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] inst_out,
    output logic [31:0]       pc_out,
    output logic [1:0]        err_out,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              fire;
    logic              out_of_range;
    logic              misaligned;
    logic              fault;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       pc_high;

    // The response slot frees up when empty or when it is consumed this cycle.
    assign req_ready = !rst && (!rsp_valid || rsp_ready);
    assign fire      = req_valid && req_ready;

    assign word_idx = pc_in[ADDR_W+1:2];

    // The shift leaves nothing when the whole pc is word index plus byte offset,
    // so at ADDR_W=30 the range check collapses to a constant zero.
    assign pc_high      = pc_in >> (ADDR_W + 2);
    assign out_of_range = |pc_high;
    assign misaligned   = |pc_in[1:0];
    assign fault        = out_of_range || misaligned;

    // The load port ignores reset and the handshake so a boot loader can fill
    // the memory at any time; contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Nonblocking read of mem gives read-first behaviour against a same-cycle load.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            inst_out  <= NOP_WORD;
            pc_out    <= '0;
            err_out   <= '0;
        end else if (fire) begin
            rsp_valid <= 1'b1;
            pc_out    <= pc_in;
            err_out   <= {misaligned, out_of_range};
            if (fault) begin
                inst_out <= NOP_WORD;
            end else begin
                inst_out <= mem[word_idx];
            end
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_mem_sync.sv
// Self-checking bench for inst_mem_sync: directed scenarios followed by random
// traffic, all compared against a word-level behavioural model of the memory.
module tb_inst_mem_sync;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       pc_in;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] inst_out;
    logic [31:0]       pc_out;
    logic [1:0]        err_out;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;

    inst_mem_sync #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .pc_in    (pc_in),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .inst_out (inst_out),
        .pc_out   (pc_out),
        .err_out  (err_out),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [DEPTH];
    logic        m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_pc;
    logic [1:0]  m_err;

    logic [31:0] prog [8];

    // Inputs are driven at the falling edge; this applies them across one
    // rising edge and advances the model the way the specification describes.
    task automatic apply_stimulus();
        logic        fire;
        logic        oor;
        logic        mis;
        logic        n_valid;
        logic [31:0] n_inst;
        logic [31:0] n_pc;
        logic [1:0]  n_err;
        fire    = req_valid && (!m_valid || rsp_ready) && !rst;
        oor     = (pc_in / 4) >= DEPTH;
        mis     = (pc_in % 4) != 0;
        n_valid = m_valid;
        n_inst  = m_inst;
        n_pc    = m_pc;
        n_err   = m_err;
        if (rst) begin
            n_valid = 1'b0;
            n_inst  = 32'h0;
            n_pc    = 32'h0;
            n_err   = 2'b00;
        end else if (fire) begin
            n_valid = 1'b1;
            n_pc    = pc_in;
            n_err   = {mis, oor};
            n_inst  = (oor || mis) ? 32'h0 : model_mem[int'(pc_in / 4)];
        end else if (rsp_ready) begin
            n_valid = 1'b0;
        end
        if (ld_we) begin
            model_mem[int'(ld_addr)] = ld_data;
        end
        @(posedge clk);
        @(negedge clk);
        m_valid = n_valid;
        m_inst  = n_inst;
        m_pc    = n_pc;
        m_err   = n_err;
    endtask

    task automatic check_output(input string tag);
        checks++;
        assert (rsp_valid === m_valid) else begin
            failures++;
            $error("[TB] FAIL %s rsp_valid: observed %b expected %b", tag, rsp_valid, m_valid);
        end
        checks++;
        assert (inst_out === m_inst) else begin
            failures++;
            $error("[TB] FAIL %s inst_out: observed %h expected %h", tag, inst_out, m_inst);
        end
        checks++;
        assert (pc_out === m_pc) else begin
            failures++;
            $error("[TB] FAIL %s pc_out: observed %h expected %h", tag, pc_out, m_pc);
        end
        checks++;
        assert (err_out === m_err) else begin
            failures++;
            $error("[TB] FAIL %s err_out: observed %b expected %b", tag, err_out, m_err);
        end
        if (!rst) begin
            checks++;
            assert (req_ready === (!m_valid || rsp_ready)) else begin
                failures++;
                $error("[TB] FAIL %s req_ready: observed %b expected %b", tag, req_ready, !m_valid || rsp_ready);
            end
        end
    endtask

    task automatic expect_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic fetch(input logic [31:0] pc);
        req_valid = 1'b1;
        pc_in     = pc;
        apply_stimulus();
        req_valid = 1'b0;
    endtask

    initial begin
        prog[0] = 32'h3409_000A; prog[1] = 32'h2001_0001;
        prog[2] = 32'h0121_4822; prog[3] = 32'h350A_0001;
        prog[4] = 32'h2001_0000; prog[5] = 32'h1029_FFFA;
        prog[6] = 32'h0800_0C01; prog[7] = 32'h0000_0000;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        m_valid = 1'b0; m_inst = 32'h0; m_pc = 32'h0; m_err = 2'b00;

        // Reset with a simultaneous load of the last word.
        rst = 1'b1; req_valid = 1'b1; pc_in = 32'h0; rsp_ready = 1'b0;
        ld_we = 1'b1; ld_addr = 10'(DEPTH - 1); ld_data = 32'hCAFE_F00D;
        @(negedge clk);
        apply_stimulus();
        check_output("reset");
        rst = 1'b0; req_valid = 1'b0;

        for (int i = 0; i < DEPTH - 1; i++) begin
            ld_we   = 1'b1;
            ld_addr = 10'(i);
            ld_data = (i < 8) ? prog[i] : $urandom;
            apply_stimulus();
        end
        ld_we = 1'b0;
        check_output("after_load");

        // Back-to-back fetch of the program.
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            fetch(32'(4 * i));
            check_output("b2b");
            expect_value("b2b_prog", inst_out, prog[i]);
            expect_value("b2b_pc", pc_out, 32'(4 * i));
        end

        // Stall with a response for pc=8 pending and pc=16 queued.
        fetch(32'd8);
        rsp_ready = 1'b0; req_valid = 1'b1; pc_in = 32'd16;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus();
            check_output("stall");
            expect_value("stall_inst", inst_out, 32'h0121_4822);
            expect_value("stall_pc", pc_out, 32'd8);
            expect_value("stall_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        expect_value("unstall_ready", {31'd0, req_ready}, 32'd1);
        apply_stimulus();
        req_valid = 1'b0;
        check_output("unstall");
        expect_value("unstall_pc", pc_out, 32'd16);

        // Fault decoding.
        fetch(32'h0000_1000);
        check_output("fault_oor");
        expect_value("fault_oor_err", {30'd0, err_out}, 32'd1);
        fetch(32'h0000_0006);
        check_output("fault_mis");
        expect_value("fault_mis_err", {30'd0, err_out}, 32'd2);
        fetch(32'h0000_1002);
        check_output("fault_both");
        expect_value("fault_both_err", {30'd0, err_out}, 32'd3);
        fetch(32'h0000_0FFC);
        check_output("last_word");
        expect_value("last_word_inst", inst_out, 32'hCAFE_F00D);

        // Load and fetch of the same word in one cycle.
        ld_we = 1'b1; ld_addr = 10'd3; ld_data = 32'hDEAD_BEEF;
        fetch(32'd12);
        ld_we = 1'b0;
        check_output("collide_old");
        expect_value("collide_old_inst", inst_out, 32'h350A_0001);
        fetch(32'd12);
        check_output("collide_new");
        expect_value("collide_new_inst", inst_out, 32'hDEAD_BEEF);

        // Reset while a response is stalled.
        fetch(32'd20);
        rsp_ready = 1'b0;
        apply_stimulus();
        check_output("pre_reset_stall");
        rst = 1'b1;
        apply_stimulus();
        check_output("mid_reset");
        expect_value("mid_reset_valid", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b0; rsp_ready = 1'b1;
        fetch(32'd4);
        check_output("post_reset_fetch");
        expect_value("post_reset_inst", inst_out, 32'h2001_0001);

        // Idle drain.
        for (int i = 0; i < 5; i++) begin
            apply_stimulus();
            check_output("idle");
        end
        expect_value("idle_pc", pc_out, 32'd4);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            req_valid = $urandom_range(0, 3) != 0;
            rsp_ready = $urandom_range(0, 3) != 0;
            case ($urandom_range(0, 4))
                0, 1:    pc_in = {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
                2:       pc_in = {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
                3:       pc_in = $urandom | 32'h0000_1000;
                default: pc_in = 32'(4 * $urandom_range(0, 7));
            endcase
            ld_we   = $urandom_range(0, 3) == 0;
            ld_addr = (pc_in[1:0] == 2'b00 && $urandom_range(0, 1) == 1) ? pc_in[11:2]
                                                                          : 10'($urandom_range(0, DEPTH - 1));
            ld_data = $urandom;
            rst     = $urandom_range(0, 49) == 0;
            #1;
            if (!rst) begin
                checks++;
                assert (req_ready === (!m_valid || rsp_ready)) else begin
                    failures++;
                    $error("[TB] FAIL rand_ready: observed %b expected %b", req_ready, !m_valid || rsp_ready);
                end
            end
            apply_stimulus();
            check_output("random");
        end
        rst = 1'b0; req_valid = 1'b0; ld_we = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
